// File: rtl/router_output_arbiter_if.sv
// Output-port bundle for router_output_arbiter.
//   master : environment side (drives offers and downstreamReady, observes results)
//   slave  : arbiter side (consumes offers, drives outputFlit/outputValid/portBlock*/errorFlag)
// An offer is {valid, type[1:0], payload}; the link flit drops the valid bit.
interface router_output_arbiter_if #(
  parameter int flitWidth         = 16,
  parameter int modifiedFlitWidth = flitWidth + 1
);
  logic [modifiedFlitWidth-1:0] portIn0;
  logic [modifiedFlitWidth-1:0] portIn1;
  logic [modifiedFlitWidth-1:0] portIn2;
  logic [modifiedFlitWidth-1:0] portIn3;
  logic                         downstreamReady;
  logic [flitWidth-1:0]         outputFlit;
  logic                         outputValid;
  logic                         portBlock0;
  logic                         portBlock1;
  logic                         portBlock2;
  logic                         portBlock3;
  logic                         errorFlag;

  modport master (
    output portIn0, portIn1, portIn2, portIn3, downstreamReady,
    input  outputFlit, outputValid, portBlock0, portBlock1, portBlock2, portBlock3, errorFlag
  );

  modport slave (
    input  portIn0, portIn1, portIn2, portIn3, downstreamReady,
    output outputFlit, outputValid, portBlock0, portBlock1, portBlock2, portBlock3, errorFlag
  );
endinterface

// File: rtl/router_output_arbiter.sv
// One egress port of the 5-port router. Collects the four offers aimed at this
// port, grants them round-robin with a per-packet (wormhole) lock, registers the
// winning flit towards the downstream link and drives per-source block signals.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave modport (offers portIn0..3, downstreamReady in; outputFlit,
//          outputValid, portBlock0..3 (combinational), errorFlag (sticky) out)
module router_output_arbiter #(
  parameter int flitWidth         = 16,
  parameter int modifiedFlitWidth = flitWidth + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  router_output_arbiter_if.slave  bus
);
  localparam int NUM_SRC = 4;
  localparam logic [1:0] T_HEAD   = 2'b00;
  localparam logic [1:0] T_BODY   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_q, state_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [1:0]           owner_q, owner_d;
  logic                 out_valid_q, out_valid_d;
  logic [flitWidth-1:0] out_flit_q, out_flit_d;
  logic                 err_q, err_d;

  logic [NUM_SRC-1:0][modifiedFlitWidth-1:0] offer;
  logic [NUM_SRC-1:0]                        vld;
  logic [NUM_SRC-1:0][1:0]                   typ;
  logic [NUM_SRC-1:0]                        elig, grant, blk;
  logic                                      can_load, grant_any, viol;
  logic [1:0]                                win;

  assign offer = {bus.portIn3, bus.portIn2, bus.portIn1, bus.portIn0};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign vld[g] = offer[g][flitWidth];
    assign typ[g] = offer[g][flitWidth-1:flitWidth-2];
  end

  // First eligible source scanning ptr, ptr+1, ... mod 4. The scan runs from the
  // far end so the nearest hit is written last. Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [NUM_SRC-1:0] e, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (e[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    err_d       = err_q;
    elig        = '0;
    grant       = '0;
    grant_any   = 1'b0;
    viol        = 1'b0;
    win         = owner_q;
    can_load    = !out_valid_q || bus.downstreamReady;

    case (state_q)
      IDLE: begin
        for (int i = 0; i < NUM_SRC; i++)
          elig[i] = vld[i] && (typ[i] == T_HEAD || typ[i] == T_SINGLE);
        // Any valid offer that is not eligible here is a body/tail with no packet open.
        viol = |(vld & ~elig);
        {grant_any, win} = rr_pick(elig, rr_ptr_q);
      end
      LOCKED: begin
        if (vld[owner_q]) begin
          if (typ[owner_q] == T_BODY || typ[owner_q] == T_TAIL) grant_any = 1'b1;
          else                                                  viol      = 1'b1;
        end
      end
      default: ;
    endcase

    // While in reset nothing is consumed, so every valid offer is blocked.
    grant_any = grant_any && can_load && !rst;
    viol      = viol && !rst;

    if (grant_any) begin
      grant[win]  = 1'b1;
      out_flit_d  = offer[win][flitWidth-1:0];
      out_valid_d = 1'b1;
      case (typ[win])
        T_SINGLE: rr_ptr_d = win + 2'd1;
        T_HEAD: begin
          owner_d = win;
          state_d = LOCKED;
        end
        T_TAIL: begin
          state_d  = IDLE;
          rr_ptr_d = owner_q + 2'd1;
        end
        default: ;
      endcase
    end else if (bus.downstreamReady) begin
      out_valid_d = 1'b0;
    end

    if (viol) err_d = 1'b1;
    blk = vld & ~grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      err_q       <= err_d;
    end
  end

  assign bus.outputFlit  = out_flit_q;
  assign bus.outputValid = out_valid_q;
  assign bus.errorFlag   = err_q;
  assign {bus.portBlock3, bus.portBlock2, bus.portBlock1, bus.portBlock0} = blk;
endmodule

// File: tb/tb_router_output_arbiter.sv
// Self-checking bench for router_output_arbiter: directed scenarios followed by
// randomized packet traffic, all compared against a packet-level reference model.
module tb_router_output_arbiter;
  localparam logic [16:0] NONE = 17'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_output_arbiter_if #(.flitWidth(16)) bus ();

  router_output_arbiter #(.flitWidth(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: which source (if any) holds the port, next preferred
  // source, output register contents and the sticky error.
  bit          m_lock;
  int          m_owner, m_rr, m_grant;
  bit          m_ov, m_err;
  logic [15:0] m_of;

  // Random source generators.
  logic [16:0] g_off [4];
  int          g_rem [4];
  bit          g_inpkt [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] fl(input logic [1:0] t, input logic [13:0] p);
    return {1'b1, t, p};
  endfunction

  // One clock cycle: drive, check blocks mid-cycle, clock, check registered outputs.
  task automatic cyc(input logic [3:0][16:0] o, input bit rdy, input bit r);
    int          t, s, grant;
    bit          errnow;
    logic [3:0]  exp_blk;
    bus.portIn0 = o[0]; bus.portIn1 = o[1]; bus.portIn2 = o[2]; bus.portIn3 = o[3];
    bus.downstreamReady = rdy;
    rst = r;
    #1;
    grant = -1; errnow = 0;
    if (!r) begin
      if (!m_lock) begin
        for (int k = 0; k < 4; k++) begin
          s = (m_rr + k) % 4;
          t = int'(o[s][15:14]);
          if (o[s][16]) begin
            if (t == 1 || t == 2) errnow = 1;
            else if (grant < 0)   grant = s;
          end
        end
      end else if (o[m_owner][16]) begin
        t = int'(o[m_owner][15:14]);
        if (t == 0 || t == 3) errnow = 1;
        else                  grant = m_owner;
      end
      if (m_ov && !rdy) grant = -1;
    end
    for (int i = 0; i < 4; i++) exp_blk[i] = o[i][16] && (grant != i);
    chk("portBlock", {28'h0, bus.portBlock3, bus.portBlock2, bus.portBlock1, bus.portBlock0},
        {28'h0, exp_blk});
    m_grant = grant;
    @(posedge clk);
    if (r) begin
      m_lock = 0; m_owner = 0; m_rr = 0; m_ov = 0; m_of = '0; m_err = 0;
    end else begin
      if (grant >= 0) begin
        m_of = o[grant][15:0];
        m_ov = 1;
        t = int'(o[grant][15:14]);
        if (t == 3) m_rr = (grant + 1) % 4;
        else if (t == 0) begin m_lock = 1; m_owner = grant; end
        else if (t == 2) begin m_lock = 0; m_rr = (m_owner + 1) % 4; end
      end else if (rdy) begin
        m_ov = 0;
      end
      if (errnow) m_err = 1;
    end
    #1;
    chk("outputValid", {31'h0, bus.outputValid}, {31'h0, m_ov});
    chk("outputFlit",  {16'h0, bus.outputFlit},  {16'h0, m_of});
    chk("errorFlag",   {31'h0, bus.errorFlag},   {31'h0, m_err});
    @(negedge clk);
  endtask

  task automatic c4(input logic [16:0] o0, o1, o2, o3, input bit rdy, input bit r);
    cyc({o3, o2, o1, o0}, rdy, r);
  endtask

  task automatic gen(input int i);
    int r;
    if (g_inpkt[i] && $urandom_range(3) == 0) g_off[i] = NONE;
    else if (g_inpkt[i]) begin
      if (g_rem[i] > 0) begin g_off[i] = fl(2'd1, 14'($urandom)); g_rem[i]--; end
      else begin g_off[i] = fl(2'd2, 14'($urandom)); g_inpkt[i] = 0; end
    end else begin
      r = $urandom_range(9);
      if (r <= 2)      g_off[i] = NONE;
      else if (r <= 5) g_off[i] = fl(2'd3, 14'($urandom));
      else if (r <= 8) begin
        g_off[i] = fl(2'd0, 14'($urandom));
        g_rem[i] = $urandom_range(2);
        g_inpkt[i] = 1;
      end else if ($urandom_range(9) == 0) g_off[i] = fl(2'd1, 14'($urandom));
      else g_off[i] = NONE;
    end
  endtask

  initial begin
    bit r, rdy;
    bus.portIn0 = NONE; bus.portIn1 = NONE; bus.portIn2 = NONE; bus.portIn3 = NONE;
    bus.downstreamReady = 1'b1;
    m_lock = 0; m_owner = 0; m_rr = 0; m_ov = 0; m_of = '0; m_err = 0; m_grant = -1;
    @(negedge clk);

    // Reset, then a single-flit packet on source 2.
    c4(NONE, NONE, NONE, NONE, 1, 1);
    c4(NONE, NONE, fl(2'd3, 14'h2A), NONE, 1, 0);
    chk("single_flit_value", {16'h0, bus.outputFlit}, 32'h0000_C02A);
    // Pointer now at 3: source 3 must beat source 0.
    c4(fl(2'd3, 14'h10), NONE, NONE, fl(2'd3, 14'h13), 1, 0);
    chk("rr_after_single", {16'h0, bus.outputFlit}, 32'h0000_C013);

    // Heads on all four sources with pointer 0.
    c4(NONE, NONE, NONE, NONE, 1, 1);
    c4(fl(0, 14'h100), fl(0, 14'h101), fl(0, 14'h102), fl(0, 14'h103), 1, 0);
    c4(fl(1, 14'h200), fl(0, 14'h101), fl(0, 14'h102), fl(0, 14'h103), 1, 0);
    c4(fl(1, 14'h201), fl(0, 14'h101), fl(0, 14'h102), fl(0, 14'h103), 1, 0);
    c4(fl(2, 14'h202), fl(0, 14'h101), fl(0, 14'h102), fl(0, 14'h103), 1, 0);
    c4(NONE,           fl(0, 14'h101), fl(0, 14'h102), fl(0, 14'h103), 1, 0);
    chk("next_winner_src1", {16'h0, bus.outputFlit}, 32'h0000_0101);
    c4(NONE, fl(2, 14'h211), fl(0, 14'h102), fl(0, 14'h103), 1, 0);
    c4(NONE, NONE,           fl(0, 14'h102), fl(0, 14'h103), 1, 0);
    c4(NONE, NONE,           fl(2, 14'h212), fl(0, 14'h103), 1, 0);
    c4(NONE, NONE,           NONE,           fl(0, 14'h103), 1, 0);
    c4(NONE, NONE,           NONE,           fl(2, 14'h213), 1, 0);
    c4(NONE, NONE, NONE, NONE, 1, 0);

    // Wormhole with a 3-cycle downstream stall.
    c4(NONE, NONE, NONE, NONE, 1, 1);
    c4(NONE, NONE, NONE, fl(0, 14'h300), 1, 0);
    repeat (3) c4(NONE, NONE, NONE, fl(1, 14'h301), 0, 0);
    chk("stall_hold", {16'h0, bus.outputFlit}, 32'h0000_0300);
    c4(NONE, NONE, NONE, fl(1, 14'h301), 1, 0);
    c4(NONE, NONE, NONE, fl(2, 14'h302), 1, 0);
    c4(NONE, NONE, NONE, NONE, 1, 0);

    // Rotation between two always-offering single-flit sources.
    c4(NONE, NONE, NONE, NONE, 1, 1);
    repeat (8) c4(NONE, fl(3, 14'h401), NONE, fl(3, 14'h403), 1, 0);

    // Protocol error: sticky until reset.
    c4(NONE, NONE, NONE, NONE, 1, 1);
    c4(fl(1, 14'h500), NONE, NONE, NONE, 1, 0);
    repeat (3) c4(NONE, NONE, NONE, NONE, 1, 0);
    chk("error_sticky", {31'h0, bus.errorFlag}, 32'h1);
    c4(NONE, NONE, NONE, NONE, 1, 1);

    // Reset in the middle of a packet drops the lock.
    c4(NONE, NONE, fl(0, 14'h600), NONE, 1, 0);
    c4(NONE, NONE, fl(1, 14'h601), NONE, 1, 0);
    c4(NONE, NONE, fl(1, 14'h602), NONE, 1, 1);
    c4(fl(0, 14'h700), NONE, NONE, NONE, 1, 0);
    chk("head_after_reset", {16'h0, bus.outputFlit}, 32'h0000_0700);

    // Randomized traffic with stalls and occasional resets.
    for (int i = 0; i < 4; i++) begin g_off[i] = NONE; g_rem[i] = 0; g_inpkt[i] = 0; end
    c4(NONE, NONE, NONE, NONE, 1, 1);
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(79) == 0);
      rdy = ($urandom_range(3) != 0);
      cyc({g_off[3], g_off[2], g_off[1], g_off[0]}, rdy, r);
      for (int i = 0; i < 4; i++) begin
        if (r) begin g_inpkt[i] = 0; g_rem[i] = 0; g_off[i] = NONE; end
        else if (!g_off[i][16] || m_grant == i) gen(i);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
